// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the instruction register / datapath and the
// multicycle control FSM. The datapath side drives the decoded instruction
// fields and consumes the strobes and mux selects.
interface multicycle_ctrl_fsm_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;

    logic               PCS;
    logic               RegW;
    logic               MemW;
    logic [1:0]         FlagW;
    logic               NextPC;
    logic               IRWrite;
    logic               AdrSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUControl;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [STATE_W-1:0] State;

    modport master (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, State
    );

    modport slave (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM-style control unit: Moore main FSM plus ALU decode.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | load IR, PC <= PC + 4
// DECODE   | read registers, PC + 8 available on ALU
// MEMADR   | compute load/store address (base + imm)
// MEMREAD  | read memory at ALU address
// MEMWB    | write loaded data to register file
// MEMWRITE | write store data to memory
// EXECUTER | ALU op with register operand B
// EXECUTEI | ALU op with immediate operand B
// ALUWB    | write ALU result (suppressed for CMP)
// BRANCH   | PC <= PC + 8 + offset
//
// Moore outputs are registered: each register is loaded with the value
// belonging to the state being entered, so outputs change together with
// State. The reset values are the FETCH values, so the cycle right after
// reset release already presents the fetch strobes; those strobes are
// gated by reset so nothing fires while reset is held low.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.slave  ctrl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic       irwrite_q, nextpc_q, adrsrc_q;
    logic       regw_q, memw_q, aluop_q, branch_q;
    logic [1:0] srca_q, srcb_q, ressrc_q;
    logic [1:0] alu_ctrl, flag_w;
    logic [3:0] cmd;
    logic       is_cmp;

    assign cmd    = ctrl.Funct[4:1];
    assign is_cmp = (cmd == 4'b1010);

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.Op)
                    2'b00:   state_d = ctrl.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = ctrl.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register and Moore outputs for the state being entered.
    // NoWrite (CMP) is sampled only on entry to ALUWB and held in regw_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            irwrite_q <= 1'b1;
            nextpc_q  <= 1'b1;
            adrsrc_q  <= 1'b0;
            srca_q    <= 2'b01;
            srcb_q    <= 2'b10;
            ressrc_q  <= 2'b10;
            regw_q    <= 1'b0;
            memw_q    <= 1'b0;
            aluop_q   <= 1'b0;
            branch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            irwrite_q <= (state_d == S_FETCH);
            nextpc_q  <= (state_d == S_FETCH);
            adrsrc_q  <= (state_d == S_MEMREAD) || (state_d == S_MEMWRITE);
            srca_q    <= ((state_d == S_FETCH) || (state_d == S_DECODE)) ? 2'b01 : 2'b00;
            if ((state_d == S_FETCH) || (state_d == S_DECODE))
                srcb_q <= 2'b10;
            else if ((state_d == S_MEMADR) || (state_d == S_EXECUTEI) || (state_d == S_BRANCH))
                srcb_q <= 2'b01;
            else
                srcb_q <= 2'b00;
            if ((state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_BRANCH))
                ressrc_q <= 2'b10;
            else if (state_d == S_MEMWB)
                ressrc_q <= 2'b01;
            else
                ressrc_q <= 2'b00;
            regw_q    <= (state_d == S_MEMWB) || ((state_d == S_ALUWB) && !is_cmp);
            memw_q    <= (state_d == S_MEMWRITE);
            aluop_q   <= (state_d == S_EXECUTER) || (state_d == S_EXECUTEI);
            branch_q  <= (state_d == S_BRANCH);
        end
    end

    // ALU decode: only meaningful while an EXECUTE state drives the ALU.
    always_comb begin
        alu_ctrl = 2'b00;
        flag_w   = 2'b00;
        if (aluop_q) begin
            case (cmd)
                4'b0100: alu_ctrl = 2'b00;
                4'b0010: alu_ctrl = 2'b01;
                4'b0000: alu_ctrl = 2'b10;
                4'b1100: alu_ctrl = 2'b11;
                4'b1010: alu_ctrl = 2'b01;
                default: alu_ctrl = 2'b00;
            endcase
            flag_w[1] = ctrl.Funct[0];
            flag_w[0] = ctrl.Funct[0] & ~alu_ctrl[1];
        end
    end

    assign ctrl.IRWrite    = irwrite_q & reset;
    assign ctrl.NextPC     = nextpc_q & reset;
    assign ctrl.AdrSrc     = adrsrc_q;
    assign ctrl.ALUSrcA    = srca_q;
    assign ctrl.ALUSrcB    = srcb_q;
    assign ctrl.ResultSrc  = ressrc_q;
    assign ctrl.RegW       = regw_q;
    assign ctrl.MemW       = memw_q;
    assign ctrl.FlagW      = flag_w;
    assign ctrl.ALUControl = alu_ctrl;
    assign ctrl.PCS        = branch_q | (regw_q & (ctrl.Rd == 4'hF));
    assign ctrl.ImmSrc     = ctrl.Op;
    assign ctrl.RegSrc     = {ctrl.Op == 2'b01, ctrl.Op == 2'b10};
    assign ctrl.State      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed instructions, a per-class path
// model and a per-state output table, checked on every falling edge.
module tb_multicycle_ctrl_fsm;
    localparam int STATE_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.STATE_W(STATE_W)) bus ();

    multicycle_ctrl_fsm #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       nextpc;
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [1:0] aluc;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
    } outs_t;

    int vectors    = 0;
    int miscompares = 0;

    logic       chk_en = 1'b0;
    int         exp_st;
    int         exp_step;
    logic [1:0] inst_op;
    logic [5:0] inst_f;
    logic [3:0] inst_rd;
    logic [3:0] snap_state [6];
    outs_t      snap_out [6];

    // Expected outputs from the per-state table of the control unit.
    function automatic outs_t model_out(input int st, input logic [1:0] op,
                                        input logic [5:0] f, input logic [3:0] rd);
        outs_t o;
        logic  aluop;
        logic  branch;
        o      = '0;
        aluop  = 1'b0;
        branch = 1'b0;
        o.immsrc = op;
        o.regsrc = {op == 2'b01, op == 2'b10};
        case (st)
            0: begin o.irwrite = 1; o.nextpc = 1; o.srca = 2'b01; o.srcb = 2'b10; o.ressrc = 2'b10; end
            1: begin o.srca = 2'b01; o.srcb = 2'b10; o.ressrc = 2'b10; end
            2: o.srcb = 2'b01;
            3: o.adrsrc = 1;
            4: begin o.ressrc = 2'b01; o.regw = 1; end
            5: begin o.adrsrc = 1; o.memw = 1; end
            6: aluop = 1;
            7: begin o.srcb = 2'b01; aluop = 1; end
            8: o.regw = (f[4:1] != 4'b1010);
            9: begin o.srcb = 2'b01; o.ressrc = 2'b10; branch = 1; end
            default: ;
        endcase
        if (aluop) begin
            case (f[4:1])
                4'b0100: o.aluc = 2'b00;
                4'b0010: o.aluc = 2'b01;
                4'b0000: o.aluc = 2'b10;
                4'b1100: o.aluc = 2'b11;
                4'b1010: o.aluc = 2'b01;
                default: o.aluc = 2'b00;
            endcase
            o.flagw = {f[0], f[0] & (o.aluc == 2'b00 || o.aluc == 2'b01)};
        end
        o.pcs = branch | (o.regw & (rd == 4'hF));
        return o;
    endfunction

    // Expected state walk per instruction class.
    task automatic build_path(input logic [1:0] op, input logic [5:0] f,
                              output int p[6], output int n);
        p = '{default: 0};
        p[0] = 0;
        p[1] = 1;
        case (op)
            2'b01: if (f[0]) begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
                   else      begin p[2] = 2; p[3] = 5; n = 4; end
            2'b00: begin p[2] = f[5] ? 7 : 6; p[3] = 8; n = 4; end
            2'b10: begin p[2] = 9; n = 3; end
            default: n = 2;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            outs_t e;
            outs_t a;
            e = model_out(exp_st, inst_op, inst_f, inst_rd);
            a = '{pcs: bus.PCS, regw: bus.RegW, memw: bus.MemW, flagw: bus.FlagW,
                  nextpc: bus.NextPC, irwrite: bus.IRWrite, adrsrc: bus.AdrSrc,
                  srca: bus.ALUSrcA, srcb: bus.ALUSrcB, ressrc: bus.ResultSrc,
                  aluc: bus.ALUControl, immsrc: bus.ImmSrc, regsrc: bus.RegSrc};
            snap_state[exp_step] = bus.State;
            snap_out[exp_step]   = a;
            vectors++;
            if (bus.State !== STATE_W'(exp_st)) begin
                miscompares++;
                $display("FAIL state step %0d: got %0d expected %0d", exp_step, bus.State, exp_st);
            end
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs state %0d: got %0h expected %0h", exp_st, a, e);
            end
        end
    end

    task automatic check_reset_low(input string tag);
        chk({tag, " State"},   32'(bus.State),   32'd0);
        chk({tag, " MemW"},    32'(bus.MemW),    32'd0);
        chk({tag, " RegW"},    32'(bus.RegW),    32'd0);
        chk({tag, " IRWrite"}, 32'(bus.IRWrite), 32'd0);
        chk({tag, " NextPC"},  32'(bus.NextPC),  32'd0);
        chk({tag, " PCS"},     32'(bus.PCS),     32'd0);
        chk({tag, " FlagW"},   32'(bus.FlagW),   32'd0);
    endtask

    // Runs one instruction from FETCH; optionally perturbs Funct in ALUWB
    // or pulls reset low at a given step.
    task automatic run(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input bit perturb, input int abort_step);
        int p[6];
        int n;
        build_path(op, f, p, n);
        inst_op = op; inst_f = f; inst_rd = rd;
        bus.Op = op; bus.Funct = f; bus.Rd = rd;
        for (int i = 0; i < n; i++) begin
            exp_st = p[i];
            exp_step = i;
            chk_en = 1'b1;
            if (perturb && p[i] == 8) bus.Funct = 6'b001000;
            if (i == abort_step) begin
                @(negedge clk);
                #2 reset = 1'b0;
                #1 chk_en = 1'b0;
                check_reset_low("abort");
                @(posedge clk);
                #1 check_reset_low("abort held");
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'h0;
        #3 check_reset_low("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // LDR r3
        run(2'b01, 6'b011001, 4'd3, 0, -1);
        chk("LDR path", {12'h0, snap_state[0], snap_state[1], snap_state[2], snap_state[3], snap_state[4]}, 32'h01234);
        chk("LDR RegW", {snap_out[0].regw, snap_out[1].regw, snap_out[2].regw, snap_out[3].regw, snap_out[4].regw}, 32'b00001);
        chk("LDR MemW/PCS", {snap_out[0].memw, snap_out[1].memw, snap_out[2].memw, snap_out[3].memw, snap_out[4].memw,
                             snap_out[0].pcs, snap_out[1].pcs, snap_out[2].pcs, snap_out[3].pcs, snap_out[4].pcs}, 32'd0);

        // STR
        run(2'b01, 6'b011000, 4'd0, 0, -1);
        chk("STR path", {16'h0, snap_state[0], snap_state[1], snap_state[2], snap_state[3]}, 32'h0125);
        chk("STR MemW", {snap_out[0].memw, snap_out[1].memw, snap_out[2].memw, snap_out[3].memw}, 32'b0001);
        chk("STR AdrSrc", 32'(snap_out[3].adrsrc), 32'd1);
        chk("STR RegW", {snap_out[0].regw, snap_out[1].regw, snap_out[2].regw, snap_out[3].regw}, 32'd0);

        // ADDS r2 register
        run(2'b00, 6'b001001, 4'd2, 0, -1);
        chk("ADDS path", {16'h0, snap_state[0], snap_state[1], snap_state[2], snap_state[3]}, 32'h0168);
        chk("ADDS ALUControl", 32'(snap_out[2].aluc), 32'd0);
        chk("ADDS FlagW", 32'(snap_out[2].flagw), 32'd3);
        chk("ADDS RegW", 32'(snap_out[3].regw), 32'd1);

        // CMP immediate, Funct disturbed during ALUWB
        run(2'b00, 6'b110101, 4'd0, 1, -1);
        chk("CMP path", {16'h0, snap_state[0], snap_state[1], snap_state[2], snap_state[3]}, 32'h0178);
        chk("CMP ALUControl", 32'(snap_out[2].aluc), 32'd1);
        chk("CMP FlagW", 32'(snap_out[2].flagw), 32'd3);
        chk("CMP RegW", 32'(snap_out[3].regw), 32'd0);

        // ANDS
        run(2'b00, 6'b000001, 4'd1, 0, -1);
        chk("ANDS ALUControl", 32'(snap_out[2].aluc), 32'd2);
        chk("ANDS FlagW", 32'(snap_out[2].flagw), 32'd2);

        // B
        run(2'b10, 6'b000000, 4'd0, 0, -1);
        chk("B path", {20'h0, snap_state[0], snap_state[1], snap_state[2]}, 32'h019);
        chk("B PCS", 32'(snap_out[2].pcs), 32'd1);

        // ADD to r15
        run(2'b00, 6'b001000, 4'hF, 0, -1);
        chk("ADD pc PCS", 32'(snap_out[3].pcs), 32'd1);
        chk("ADD pc FlagW", 32'(snap_out[2].flagw), 32'd0);

        // Reserved Op
        run(2'b11, 6'b111111, 4'hF, 0, -1);
        chk("Op11 path", {24'h0, snap_state[0], snap_state[1]}, 32'h01);

        // ORR imm without S, SUBS, other cmd with S
        run(2'b00, 6'b111000, 4'd4, 0, -1);
        chk("ORR ALUControl", 32'(snap_out[2].aluc), 32'd3);
        run(2'b00, 6'b000101, 4'd5, 0, -1);
        chk("SUBS FlagW", 32'(snap_out[2].flagw), 32'd3);
        run(2'b00, 6'b000011, 4'd6, 0, -1);
        chk("EORS ALUControl", 32'(snap_out[2].aluc), 32'd0);

        // STR aborted by reset in MEMWRITE, then recovery
        run(2'b01, 6'b011000, 4'd0, 0, 3);
        run(2'b00, 6'b001000, 4'd2, 0, -1);
        chk("post-reset IRWrite", 32'(snap_out[0].irwrite), 32'd1);
        chk("post-reset NextPC", 32'(snap_out[0].nextpc), 32'd1);
        chk("post-reset DECODE", 32'(snap_state[1]), 32'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
